// File: rtl/dmem_block_mover.sv
// Block copy/fill engine in front of the data memory: passes CPU loads/stores through
// when idle, otherwise owns the memory port and stalls the CPU until the transfer ends.
module dmem_block_mover #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Op,
    input  logic [AW-1:0] SrcAddr,
    input  logic [AW-1:0] DstAddr,
    input  logic [AW-1:0] Len,
    input  logic [DW-1:0] FillData,
    input  logic          CPU_MemRead,
    input  logic          CPU_MemWrite,
    input  logic [AW-1:0] CPU_Addr,
    input  logic [DW-1:0] CPU_WData,
    output logic [DW-1:0] CPU_RData,
    output logic          Stall,
    output logic          Busy,
    output logic          Done,
    output logic          MEM_READ,
    output logic          MEM_WRITE,
    output logic [AW-1:0] MEM_Addr,
    output logic [DW-1:0] MEM_WData,
    input  logic [DW-1:0] MEM_RData,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          op_q, op_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] len_q, len_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [DW-1:0] data_buf_q, data_buf_d;
    logic [DW-1:0] fill_q, fill_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            op_q       <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            data_buf_q <= '0;
            fill_q     <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            data_buf_q <= data_buf_d;
            fill_q     <= fill_d;
        end
    end

    // Start is a single-cycle request honoured only in IDLE; Done pulses once when
    // the engine returns the port, and the next Start is taken the cycle after.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        idx_d      = idx_q;
        data_buf_d = data_buf_q;
        fill_d     = fill_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    op_d   = Op;
                    src_d  = SrcAddr;
                    dst_d  = DstAddr;
                    len_d  = Len;
                    fill_d = FillData;
                    idx_d  = '0;
                    if (Len == '0)   state_d = S_DONE;
                    else if (Op)     state_d = S_WR;
                    else             state_d = S_RD;
                end
            end
            S_RD: begin
                data_buf_d = MEM_RData;
                state_d    = S_WR;
            end
            S_WR: begin
                if (idx_q == len_q - AW'(1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = op_q ? S_WR : S_RD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Memory port mux kept apart from next-state logic so the read-data path
    // never loops back through the address select.
    always_comb begin
        MEM_READ  = 1'b0;
        MEM_WRITE = 1'b0;
        MEM_Addr  = '0;
        MEM_WData = '0;
        case (state_q)
            S_IDLE: begin
                MEM_READ  = CPU_MemRead;
                MEM_WRITE = CPU_MemWrite;
                MEM_Addr  = CPU_Addr;
                MEM_WData = CPU_WData;
            end
            S_RD: begin
                MEM_READ = 1'b1;
                MEM_Addr = src_q + idx_q;
            end
            S_WR: begin
                MEM_WRITE = 1'b1;
                MEM_Addr  = dst_q + idx_q;
                MEM_WData = op_q ? fill_q : data_buf_q;
            end
            default: ;
        endcase
    end

    assign Busy      = (state_q != S_IDLE);
    assign Stall     = Busy;
    assign Done      = (state_q == S_DONE);
    assign CPU_RData = MEM_RData;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_block_mover.sv
// Directed and randomized checks of dmem_block_mover against an array-level
// reference memory model; a behavioural RAM sits on the MEM_* port.
module tb_dmem_block_mover;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Op;
  logic [7:0] SrcAddr, DstAddr, Len, FillData;
  logic       CPU_MemRead, CPU_MemWrite;
  logic [7:0] CPU_Addr, CPU_WData;
  logic [7:0] CPU_RData;
  logic       Stall, Busy, Done;
  logic       MEM_READ, MEM_WRITE;
  logic [7:0] MEM_Addr, MEM_WData, MEM_RData;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  // clock/reset block
  always #5 Clk = ~Clk;

  dmem_block_mover #(.AW(8), .DW(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Len(Len), .FillData(FillData),
    .CPU_MemRead(CPU_MemRead), .CPU_MemWrite(CPU_MemWrite),
    .CPU_Addr(CPU_Addr), .CPU_WData(CPU_WData), .CPU_RData(CPU_RData),
    .Stall(Stall), .Busy(Busy), .Done(Done),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_Addr(MEM_Addr),
    .MEM_WData(MEM_WData), .MEM_RData(MEM_RData), .dbg_state(dbg_state)
  );

  // behavioural data memory with combinational read
  logic [7:0] mem [256];
  assign MEM_RData = mem[MEM_Addr];
  always @(posedge Clk) if (MEM_WRITE) mem[MEM_Addr] <= MEM_WData;

  // reference memory, updated by the bench from the transfer rules
  logic [7:0] ref_mem [256];

  // activity monitor, sampled mid-cycle
  int busy_cnt = 0, done_cnt = 0, rd_cnt = 0, wr_cnt = 0, stall_bad = 0;
  always @(negedge Clk) begin
    if (Busy === 1'b1) busy_cnt++;
    if (Done === 1'b1) done_cnt++;
    if (Busy === 1'b1 && MEM_READ === 1'b1) rd_cnt++;
    if (Busy === 1'b1 && MEM_WRITE === 1'b1) wr_cnt++;
    if (Stall !== Busy) stall_bad++;
  end

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk({tag, "_mem_diffs"}, 32'(bad), 32'd0);
  endtask

  task automatic ref_xfer(input bit op, input logic [7:0] src, input logic [7:0] dst,
                          input int len, input logic [7:0] fill);
    logic [7:0] s, d;
    for (int i = 0; i < len; i++) begin
      s = src + 8'(i);
      d = dst + 8'(i);
      ref_mem[d] = op ? fill : ref_mem[s];
    end
  endtask

  // driver tasks; all assume the caller sits just after a rising edge
  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    CPU_MemWrite = 1'b1; CPU_Addr = a; CPU_WData = d;
    ref_mem[a] = d;
    @(posedge Clk); #1;
    CPU_MemWrite = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
    CPU_MemRead = 1'b1; CPU_Addr = a;
    #2 d = CPU_RData;
    @(posedge Clk); #1;
    CPU_MemRead = 1'b0;
  endtask

  task automatic start_xfer(input bit op, input logic [7:0] src, input logic [7:0] dst,
                            input logic [7:0] len, input logic [7:0] fill);
    Start = 1'b1; Op = op; SrcAddr = src; DstAddr = dst; Len = len; FillData = fill;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge Clk);
      if (Busy === 1'b0) begin ok = 1; break; end
    end
    chk({tag, "_finished"}, 32'(ok), 32'd1);
    @(posedge Clk); #1;
  endtask

  task automatic run_xfer(input string tag, input bit op, input logic [7:0] src,
                          input logic [7:0] dst, input logic [7:0] len, input logic [7:0] fill);
    int b0, d0, r0, w0, n, exp_busy;
    n = int'(len);
    b0 = busy_cnt; d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt;
    start_xfer(op, src, dst, len, fill);
    chk({tag, "_busy_after_start"}, 32'(Busy), 32'd1);
    wait_idle(tag, 2 * n + 10);
    ref_xfer(op, src, dst, n, fill);
    exp_busy = (n == 0) ? 1 : (op ? n + 1 : 2 * n + 1);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt - b0), 32'(exp_busy));
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_reads"}, 32'(rd_cnt - r0), 32'(op ? 0 : n));
    chk({tag, "_writes"}, 32'(wr_cnt - w0), 32'(n));
    chk_mem(tag);
  endtask

  initial begin
    logic [7:0] rd;
    int b0, d0, w0;
    Reset = 1'b1; Start = 1'b0; Op = 1'b0; SrcAddr = '0; DstAddr = '0; Len = '0;
    FillData = '0; CPU_MemRead = 1'b0; CPU_MemWrite = 1'b0; CPU_Addr = '0; CPU_WData = '0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;

    // reset state and idle passthrough
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_stall", 32'(Stall), 32'd0);
    chk("reset_done", 32'(Done), 32'd0);
    CPU_MemRead = 1'b1; CPU_Addr = 8'h33;
    #1;
    chk("idle_pass_read", 32'(MEM_READ), 32'd1);
    chk("idle_pass_addr", 32'(MEM_Addr), 32'h33);
    chk("idle_pass_nowrite", 32'(MEM_WRITE), 32'd0);
    CPU_MemRead = 1'b0;
    @(posedge Clk); #1;

    // random preload through the CPU path
    for (int a = 0; a < 256; a++) cpu_write(8'(a), 8'($urandom_range(0, 255)));

    // passthrough store then load
    CPU_MemWrite = 1'b1; CPU_Addr = 8'h10; CPU_WData = 8'h5A;
    #1;
    chk("pass_wr_en", 32'(MEM_WRITE), 32'd1);
    chk("pass_wr_addr", 32'(MEM_Addr), 32'h10);
    chk("pass_wr_data", 32'(MEM_WData), 32'h5A);
    CPU_MemWrite = 1'b0;
    @(posedge Clk); #1;
    cpu_write(8'h10, 8'h5A);
    cpu_read(8'h10, rd);
    chk("pass_rdata", 32'(rd), 32'h5A);

    // directed copy, with a CPU store in the Start cycle
    cpu_write(8'h20, 8'h11); cpu_write(8'h21, 8'h22);
    cpu_write(8'h22, 8'h33); cpu_write(8'h23, 8'h44);
    CPU_MemWrite = 1'b1; CPU_Addr = 8'h90; CPU_WData = 8'h77;
    ref_mem[8'h90] = 8'h77;
    fork
      run_xfer("copy4", 1'b0, 8'h20, 8'h80, 8'd4, 8'h00);
      begin @(posedge Clk); #1; CPU_MemWrite = 1'b0; end
    join

    // fill with address wrap
    run_xfer("fill_wrap", 1'b1, 8'h00, 8'hFE, 8'd3, 8'hA7);

    // zero length
    run_xfer("len0", 1'b0, 8'h05, 8'h06, 8'd0, 8'h00);

    // Start while busy is ignored
    b0 = busy_cnt; d0 = done_cnt;
    start_xfer(1'b0, 8'h30, 8'hB0, 8'd5, 8'h00);
    Start = 1'b1; Op = 1'b1; DstAddr = 8'hB2; Len = 8'd40; FillData = 8'hEE;
    repeat (4) @(posedge Clk);
    #1 Start = 1'b0;
    wait_idle("start_busy", 30);
    ref_xfer(1'b0, 8'h30, 8'hB0, 5, 8'h00);
    chk("start_busy_cycles", 32'(busy_cnt - b0), 32'd11);
    chk("start_busy_done", 32'(done_cnt - d0), 32'd1);
    chk_mem("start_busy");

    // overlapping forward copy
    cpu_write(8'h40, 8'h01); cpu_write(8'h41, 8'h02);
    run_xfer("overlap", 1'b0, 8'h40, 8'h41, 8'd2, 8'h00);
    chk("overlap_41", 32'(mem[8'h41]), 32'h01);
    chk("overlap_42", 32'(mem[8'h42]), 32'h01);

    // randomized transfers
    for (int t = 0; t < 20; t++) begin
      run_xfer($sformatf("rand%0d", t), 1'($urandom_range(0, 1)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 24)), 8'($urandom_range(0, 255)));
    end

    // async reset in the third write cycle of an 8-byte fill
    b0 = busy_cnt; d0 = done_cnt; w0 = wr_cnt;
    start_xfer(1'b1, 8'h00, 8'h60, 8'd8, 8'hC3);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    #1 Reset = 1'b1;
    #1;
    chk("rst_busy_drop", 32'(Busy), 32'd0);
    chk("rst_stall_drop", 32'(Stall), 32'd0);
    chk("rst_no_done", 32'(Done), 32'd0);
    #1 Reset = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    ref_xfer(1'b1, 8'h00, 8'h60, 2, 8'hC3);
    chk("rst_writes", 32'(wr_cnt - w0), 32'd2);
    chk("rst_done_pulses", 32'(done_cnt - d0), 32'd0);
    chk("rst_idle", 32'(Busy), 32'd0);
    chk_mem("rst");

    chk("stall_tracks_busy", 32'(stall_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_block_mover.md
# dmem_block_mover

Block-transfer engine that sits directly upstream of the data memory and owns its port set (read enable, write enable, address, write data, read data). When idle it passes the CPU's load/store signals straight through to the data memory. When started it takes over the port to copy a byte range (memory to memory) or fill a range with a constant, and stalls the CPU until done. It is used for buffer setup and bulk moves without per-byte load/store instruction pairs.

## Interface
Parameters:
- AW, 8, address width; addresses wrap modulo 2^AW
- DW, 8, data width

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-high; forces IDLE and clears all registers
- Start  in  1  request a transfer; sampled only in IDLE
- Op  in  1  0 = copy, 1 = fill
- SrcAddr  in  AW  copy source base (ignored for fill)
- DstAddr  in  AW  destination base
- Len  in  AW  byte count, 0..2^AW-1; 0 = no transfer
- FillData  in  DW  constant for fill
- CPU_MemRead  in  1  CPU load request
- CPU_MemWrite  in  1  CPU store request
- CPU_Addr  in  AW  CPU address
- CPU_WData  in  DW  CPU store data
- CPU_RData  out  DW  equals MEM_RData at all times
- Stall  out  1  high whenever state is not IDLE
- Busy  out  1  same as Stall; provided separately for the controller
- Done  out  1  one-cycle pulse at end of transfer
- MEM_READ  out  1  to data memory read enable
- MEM_WRITE  out  1  to data memory write enable
- MEM_Addr  out  AW  to data memory address
- MEM_WData  out  DW  to data memory write data
- MEM_RData  in  DW  from data memory; combinational read of MEM_Addr

## Operation
- States: IDLE, RD, WR, DONE. Registers: state, op, src, dst, len, idx (AW bits), buf (DW), fill value.
- IDLE: MEM_* outputs are combinational copies of the CPU_* inputs. Start=1 latches Op, SrcAddr, DstAddr, Len and FillData, and clears idx. Next state is DONE if Len=0, WR if fill, RD if copy.
- RD (copy only): MEM_READ=1, MEM_WRITE=0, MEM_Addr=src+idx (mod 2^AW). buf captures MEM_RData at the clock edge. Next state is WR.
- WR: MEM_WRITE=1, MEM_READ=0, MEM_Addr=dst+idx (mod 2^AW), MEM_WData=buf (copy) or fill value (fill). At the edge, if idx==len-1 go to DONE; otherwise idx+1 and go to RD (copy) or stay in WR (fill).
- DONE: no memory enables, Done=1 for exactly one cycle. Next state is IDLE.
- In RD, WR and DONE the CPU_* inputs are ignored and are never forwarded to memory.
- Overlapping ranges: the copy runs strictly forward, one byte at a time. With dst>src overlapping, the bytes already written are re-read; this is the defined behaviour, not an error.
- Start while not IDLE is ignored. Inputs are not re-latched mid-transfer.

## Timing
- Reset values: state=IDLE, Busy=Stall=Done=0, idx=buf=0. All latched operands are 0. MEM_* follow the CPU_* inputs as in IDLE.
- Copy of N bytes (N≥1): 2N cycles in RD/WR plus 1 in DONE. Busy is high for 2N+1 cycles starting the cycle after Start.
- Fill of N bytes: N cycles in WR plus 1 in DONE; Busy is high for N+1 cycles.
- Len=0: exactly one DONE cycle, no MEM_READ or MEM_WRITE asserted.
- A CPU access presented in the same cycle Start is sampled completes normally, since IDLE passthrough is still active that cycle.
- Done rises the cycle after the last write; the next Start is accepted the cycle after Done.
- Reset asserted mid-transfer returns the block to IDLE immediately, with no Done pulse. Bytes already written remain in memory.
- Wrap-around: src+idx and dst+idx wrap from 2^AW-1 to 0 with no error flag.

## Test plan
- Passthrough: IDLE, CPU store 0x5A to 0x10, then CPU load from 0x10 -> MEM_WRITE pulse with addr 0x10; CPU_RData=0x5A; Stall=0 throughout.
- Copy: memory 0x20..0x23 = 11,22,33,44; Start copy src=0x20, dst=0x80, Len=4 -> Busy high 9 cycles; 0x80..0x83 = 11,22,33,44; single Done pulse.
- Fill with wrap: Start fill dst=0xFE, Len=3, FillData=0xA7 -> 0xFE, 0xFF, 0x00 = 0xA7; Busy high 4 cycles.
- Len=0 and Start-while-busy: Len=0 -> one Done cycle, no memory enables. A second Start during a copy is ignored and the original transfer is unchanged.
- Overlap forward copy: 0x40=0x01, 0x41=0x02; copy src=0x40, dst=0x41, Len=2 -> 0x41=0x01, 0x42=0x01.
- Async reset mid-fill: Reset pulsed between clock edges in the 3rd WR cycle of Len=8 -> Busy drops immediately without a clock edge; no Done; exactly 2 bytes written.
